// File: rtl/fetch_line_ctrl.sv
// fetch_line_ctrl: line fetch, bypass and backup-line control upstream of the instruction select mux
module fetch_line_ctrl #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int LINE_WORDS = 4,
  parameter logic [XLEN-1:0] BOOT_PC = 32'h0000_0100,
  localparam int OFS_W = $clog2(LINE_WORDS),
  localparam int OFFSET = $clog2(ILEN/8),
  localparam int EW = XLEN + ILEN*LINE_WORDS
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            icache_req_valid_o,
  input  logic            icache_req_ready_i,
  output logic [XLEN-1:0] icache_req_addr_o,
  input  logic            icache_resp_valid_i,
  input  logic [EW-1:0]   cache_out_i,
  output logic [EW-1:0]   line_reg_o,
  output logic [EW-1:0]   line_bak_o,
  output logic [OFS_W-1:0] pc_o,
  output logic [OFS_W-1:0] prev_pc_o,
  output logic            pc_sel_o,
  output logic            line_sel_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_pc_o
);
  localparam int LA = OFFSET + OFS_W;
  localparam logic PC_CUR = 1'b0;
  localparam logic LINE_REG = 1'b0;
  localparam logic LINE_CACHE = 1'b1;
  typedef enum logic [1:0] {REQ, WAIT, RUN} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [OFS_W-1:0] prev_q;
  logic [EW-1:0] reg_q, bak_q;
  logic reg_vld, bak_vld, drop_q, drop_d;
  logic reg_hit, bak_hit, bypass, raw_vld, swap;
  assign reg_hit = reg_vld && pc_q[XLEN-1:LA] == reg_q[EW-1 -: XLEN-LA];
  assign bak_hit = bak_vld && pc_q[XLEN-1:LA] == bak_q[EW-1 -: XLEN-LA];
  assign bypass = state_q == WAIT && icache_resp_valid_i && !drop_q;
  assign raw_vld = bypass || (state_q == RUN && reg_hit);
  assign swap = state_q == RUN && !redirect_i && !reg_hit && bak_hit;
  assign instr_valid_o = raw_vld && !redirect_i;
  assign instr_pc_o = instr_valid_o ? pc_q : '0;
  assign icache_req_valid_o = state_q == REQ;
  assign icache_req_addr_o = {pc_q[XLEN-1:LA], {LA{1'b0}}};
  assign line_sel_o = bypass ? LINE_CACHE : LINE_REG;
  assign pc_sel_o = PC_CUR;
  assign pc_o = pc_q[LA-1:OFFSET];
  assign prev_pc_o = prev_q;
  assign line_reg_o = reg_q;
  assign line_bak_o = bak_q;
  // next state: a response that coincides with a redirect is still captured, so no request is left dangling
  always_comb begin
    state_d = state_q;
    drop_d = drop_q;
    case (state_q)
      REQ: if (icache_req_ready_i) begin
        state_d = WAIT;
        drop_d = redirect_i;
      end
      WAIT: if (icache_resp_valid_i) begin
        state_d = drop_q ? REQ : RUN;
        drop_d = 1'b0;
      end else if (redirect_i) drop_d = 1'b1;
      RUN: state_d = (!redirect_i && !reg_hit && !bak_hit) ? REQ : RUN;
      default: state_d = REQ;
    endcase
  end
  // pc, line and backup registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= REQ;
      pc_q <= BOOT_PC;
      prev_q <= '0;
      reg_q <= '0;
      bak_q <= '0;
      reg_vld <= 1'b0;
      bak_vld <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q <= drop_d;
      pc_q <= redirect_i ? redirect_pc_i : (instr_valid_o && instr_ready_i) ? pc_q + XLEN'(ILEN/8) : pc_q;
      if (raw_vld && instr_ready_i) prev_q <= pc_q[LA-1:OFFSET];
      if (bypass) begin
        bak_q <= reg_q;
        bak_vld <= reg_vld;
        reg_q <= cache_out_i;
        reg_vld <= 1'b1;
      end else if (swap) begin
        reg_q <= bak_q;
        bak_q <= reg_q;
        reg_vld <= bak_vld;
        bak_vld <= reg_vld;
      end
    end
  end
endmodule

// File: tb/tb_fetch_line_ctrl.sv
// tb_fetch_line_ctrl: randomized and directed checks of fetch_line_ctrl against an instruction-stream model
module tb_fetch_line_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, redirect, req_valid, req_ready, resp_valid, psel, lsel, ivalid, iready;
  logic [31:0] rpc, req_addr, ipc;
  logic [159:0] cache_out, lreg, lbak;
  logic [1:0] pco, prevo;
  fetch_line_ctrl dut (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(rpc),
    .icache_req_valid_o(req_valid), .icache_req_ready_i(req_ready), .icache_req_addr_o(req_addr),
    .icache_resp_valid_i(resp_valid), .cache_out_i(cache_out),
    .line_reg_o(lreg), .line_bak_o(lbak), .pc_o(pco), .prev_pc_o(prevo),
    .pc_sel_o(psel), .line_sel_o(lsel), .instr_valid_o(ivalid), .instr_ready_i(iready),
    .instr_pc_o(ipc)
  );
  int checks = 0, errors = 0;
  logic [31:0] exp_pc = 32'h100;
  logic [1:0] exp_prev = 2'd0;
  bit prev_known = 1'b1, stalled = 1'b0;
  int idle = 0;
  bit pend = 1'b0;
  int pend_cnt = 0, lat_min = 2, lat_max = 2;
  logic [31:0] pend_addr = 32'h0;
  bit fixed_ready = 1'b1;
  logic s_req, s_acc, s_resp, s_valid, s_lsel, s_psel, s_ready, s_rst;
  logic [31:0] s_addr, s_ipc;
  logic [1:0] s_pco, s_prev;
  logic [159:0] s_lreg, s_bak;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234 ^ (a * 32'd7);
  endfunction

  function automatic logic [159:0] line_of(input logic [31:0] a);
    logic [159:0] l;
    l[159:128] = a;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem(a + 32'(i*4));
    return l;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [159:0] sel;
    @(negedge clk);
    s_req = req_valid; s_addr = req_addr; s_acc = req_valid && req_ready; s_resp = resp_valid;
    s_valid = ivalid; s_ipc = ipc; s_pco = pco; s_prev = prevo; s_lsel = lsel; s_psel = psel;
    s_lreg = lreg; s_bak = lbak; s_ready = iready; s_rst = rst;
    if (!rst) begin
      if (req_valid) begin
        chk("req_align", 160'(req_addr[3:0]), 160'(0));
        chk("one_outstanding", 160'(pend), 160'(0));
      end
      if (redirect) chk("redirect_bubble", 160'(ivalid), 160'(0));
      if (stalled && !redirect) chk("hold_valid", 160'(ivalid), 160'(1));
      if (ivalid) begin
        sel = lsel ? cache_out : lreg;
        chk("instr_pc", 160'(ipc), 160'(exp_pc));
        chk("pc_o", 160'(pco), 160'(exp_pc[3:2]));
        chk("line_tag", 160'(sel[159:132]), 160'(ipc[31:4]));
        chk("instr_word", 160'(sel[32*pco +: 32]), 160'(mem(ipc)));
      end
      if (prev_known) chk("prev_pc", 160'(prevo), 160'(exp_prev));
      if (idle == 150) chk("progress", 160'(idle), 160'(0));
    end
    if (rst) begin
      exp_pc = 32'h100; exp_prev = 2'd0; prev_known = 1'b1; stalled = 1'b0; idle = 0;
    end else begin
      stalled = ivalid && !iready && !redirect;
      if (redirect) begin
        exp_pc = rpc; prev_known = 1'b0; idle = 0;
      end else if (ivalid && iready) begin
        exp_prev = exp_pc[3:2]; prev_known = 1'b1; exp_pc = exp_pc + 32'd4; idle = 0;
      end else idle++;
    end
    @(posedge clk);
    #1;
    if (s_rst || s_resp) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (s_acc && !s_rst) begin
      pend = 1'b1; pend_addr = s_addr; pend_cnt = int'($urandom_range(lat_min, lat_max)) - 1;
    end
    req_ready = fixed_ready || ($urandom_range(0, 99) < 60);
    resp_valid = pend && pend_cnt == 0;
    cache_out = resp_valid ? line_of(pend_addr) : {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic apply_reset();
    rst = 1'b1; redirect = 1'b0; iready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    bit seen, stale;
    logic [31:0] first_addr;
    rst = 1'b1; redirect = 1'b0; rpc = '0; iready = 1'b1; req_ready = 1'b1;
    resp_valid = 1'b0; cache_out = '0;
    apply_reset();
    tick();
    chk("rst_req_valid", 160'(s_req), 160'(1));
    chk("rst_req_addr", 160'(s_addr), 160'(32'h100));
    chk("rst_instr_valid", 160'(s_valid), 160'(0));
    chk("rst_line_reg", s_lreg, 160'(0));
    chk("rst_line_bak", s_bak, 160'(0));
    chk("rst_prev_pc", 160'(s_prev), 160'(0));
    chk("rst_pc_sel", 160'(s_psel), 160'(0));
    chk("rst_line_sel", 160'(s_lsel), 160'(0));
    n = 0; do begin tick(); n++; end while (!s_valid && n < 10);
    chk("t1_first_pc", 160'(s_ipc), 160'(32'h100));
    chk("t1_bypass_sel", 160'(s_lsel), 160'(1));
    chk("t1_latency", 160'(n), 160'(2));
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t1_seq_valid", 160'(s_valid), 160'(1));
      chk("t1_seq_pc", 160'(s_ipc), 160'(32'h100 + 32'(4*i)));
    end
    n = 0; do begin tick(); n++; end while (!s_req && n < 6);
    chk("t1_next_req", 160'(s_addr), 160'(32'h110));
    apply_reset();
    n = 0; do begin tick(); n++; end while (!(s_valid && s_ipc == 32'h100) && n < 20);
    iready = 1'b0;
    repeat (3) begin
      tick();
      chk("t2_held_valid", 160'(s_valid), 160'(1));
      chk("t2_held_pc", 160'(s_ipc), 160'(32'h104));
      chk("t2_pc_o", 160'(s_pco), 160'(1));
      chk("t2_prev", 160'(s_prev), 160'(0));
    end
    iready = 1'b1;
    tick();
    chk("t2_accept_pc", 160'(s_ipc), 160'(32'h104));
    tick();
    chk("t2_prev_after", 160'(s_prev), 160'(1));
    chk("t2_next_pc", 160'(s_ipc), 160'(32'h108));
    apply_reset();
    n = 0; do begin tick(); n++; end while (!(s_valid && s_ipc == 32'h114) && n < 30);
    chk("t3_reached", 160'(s_ipc), 160'(32'h114));
    redirect = 1'b1; rpc = 32'h104;
    tick();
    redirect = 1'b0;
    chk("t3_bubble", 160'(s_valid), 160'(0));
    chk("t3_no_req0", 160'(s_req), 160'(0));
    tick();
    chk("t3_swap_cycle", 160'(s_valid), 160'(0));
    chk("t3_no_req1", 160'(s_req), 160'(0));
    tick();
    chk("t3_valid", 160'(s_valid), 160'(1));
    chk("t3_pc", 160'(s_ipc), 160'(32'h104));
    chk("t3_sel", 160'(s_lsel), 160'(0));
    chk("t3_reg_tag", 160'(s_lreg[159:128]), 160'(32'h100));
    chk("t3_bak_tag", 160'(s_bak[159:128]), 160'(32'h110));
    lat_min = 4; lat_max = 4;
    apply_reset();
    n = 0; do begin tick(); n++; end while (!(s_acc && s_addr == 32'h110) && n < 40);
    chk("t4_req110", 160'(s_addr), 160'(32'h110));
    redirect = 1'b1; rpc = 32'h200;
    tick();
    redirect = 1'b0;
    seen = 1'b0; stale = 1'b0; first_addr = 32'hDEAD_BEEF; n = 0;
    do begin
      tick(); n++;
      if (s_req && !seen) begin seen = 1'b1; first_addr = s_addr; end
      if (s_valid && s_ipc[31:4] == 28'h11) stale = 1'b1;
    end while (!(s_valid && s_ipc == 32'h200) && n < 40);
    chk("t4_next_req", 160'(first_addr), 160'(32'h200));
    chk("t4_stale", 160'(stale), 160'(0));
    chk("t4_reach200", 160'(s_ipc), 160'(32'h200));
    lat_min = 2; lat_max = 2;
    redirect = 1'b1; rpc = 32'hFFFF_FFF0;
    tick();
    redirect = 1'b0;
    n = 0; do begin tick(); n++; end while (!(s_valid && s_ipc == 32'hFFFF_FFFC) && n < 40);
    chk("t5_last", 160'(s_ipc), 160'(32'hFFFF_FFFC));
    n = 0; do begin tick(); n++; end while (!s_req && n < 10);
    chk("t5_wrap_req", 160'(s_addr), 160'(0));
    n = 0; do begin tick(); n++; end while (!s_valid && n < 20);
    chk("t5_wrap_pc", 160'(s_ipc), 160'(0));
    apply_reset();
    n = 0; do begin tick(); n++; end while (!s_acc && n < 10);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_resp_in_rst", 160'(s_resp), 160'(1));
    rst = 1'b0;
    tick();
    chk("t6_req_valid", 160'(s_req), 160'(1));
    chk("t6_req_addr", 160'(s_addr), 160'(32'h100));
    chk("t6_instr_valid", 160'(s_valid), 160'(0));
    chk("t6_line_reg", s_lreg, 160'(0));
    chk("t6_line_bak", s_bak, 160'(0));
    chk("t6_prev", 160'(s_prev), 160'(0));
    lat_min = 1; lat_max = 4; fixed_ready = 1'b0;
    apply_reset();
    repeat (3000) begin
      iready = $urandom_range(0, 99) < 70;
      redirect = $urandom_range(0, 99) < 3;
      case ($urandom_range(0, 7))
        0: rpc = 32'h100;
        1: rpc = 32'h104;
        2: rpc = 32'h10C;
        3: rpc = 32'h110;
        4: rpc = 32'h118;
        5: rpc = 32'h200;
        6: rpc = 32'hFFFF_FFF4;
        default: rpc = $urandom() & 32'hFFFF_FFFC;
      endcase
      tick();
    end
    redirect = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_line_ctrl.md
Name: fetch_line_ctrl

Overview:
- Fetch-side controller directly upstream of the instruction select mux.
- Issues line requests to the icache and captures returned lines into a line register and a one-entry backup register.
- Tracks the fetch PC and drives the PC-select and line-select controls plus the word offsets consumed by the mux.
- Presents a valid/ready instruction stream to decode; zero-bubble bypass on line arrival; backup-line hit on redirect or sequential line change.

Parameters:
- XLEN, 32, fetch address width.
- ILEN, 32, instruction width.
- LINE_WORDS, 4, instructions per icache line (power of 2, >=2); OFS_W = log2(LINE_WORDS), OFFSET = log2(ILEN/8).
- BOOT_PC, 32'h0000_0100, fetch PC after reset (ILEN/8-aligned).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- redirect_i  in  1  PC redirect from execute/branch unit
- redirect_pc_i  in  XLEN  redirect target
- icache_req_valid_o  out  1  line request valid
- icache_req_ready_i  in  1  icache accepts request
- icache_req_addr_o  out  XLEN  line-aligned request address (low OFFSET+OFS_W bits zero)
- icache_resp_valid_i  in  1  cache_out_i valid this cycle
- cache_out_i  in  icache_out_t  returned line {pc, line}
- line_reg_o  out  icache_out_t  current line register
- line_bak_o  out  icache_out_t  backup line register
- pc_o  out  OFS_W  word offset of current PC
- prev_pc_o  out  OFS_W  word offset of last consumed instruction
- pc_sel_o  out  pc_src_t  PC mux select
- line_sel_o  out  line_src_t  line mux select
- instr_valid_o  out  1  instruction valid to decode
- instr_ready_i  in  1  decode accepts instruction
- instr_pc_o  out  XLEN  full PC of presented instruction

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - pc <= BOOT_PC; reg_vld, bak_vld, drop <= 0; state <= REQ.
  - All outputs 0, except pc_sel_o=current_pc and line_sel_o=line_reg.
- Line address: la(x) = x[XLEN-1:OFFSET+OFS_W]. Word offset: x[OFFSET+OFS_W-1:OFFSET], driven on pc_o.
- States:
  - REQ: icache_req_valid_o=1, icache_req_addr_o=la(pc)<<(OFFSET+OFS_W). On req_ready -> WAIT. Request held stable until accepted.
  - WAIT: on icache_resp_valid_i with drop=0:
    - line_sel_o=cache_out; instr_valid_o=1 (bypass).
    - line_bak <= line_reg, bak_vld <= reg_vld; line_reg <= cache_out_i; reg_vld <= 1 -> RUN.
    - A bypass instruction not consumed that cycle is re-presented next cycle from line_reg.
  - WAIT with drop=1: response discarded, drop <= 0, -> REQ.
  - RUN: line_sel_o=line_reg, pc_sel_o=current_pc, instr_valid_o=1.
- Handshake (valid & ready):
  - prev_pc <= word offset of pc; pc <= pc + ILEN/8.
  - Wraps at 2^XLEN to 0.
- Line change: needed on consuming the last word (offset LINE_WORDS-1), or on a redirect to a new line.
  - If la(new pc)==la(line_reg.pc) and reg_vld: stay in RUN, no request.
  - Else if bak_vld and la(new pc)==la(line_bak.pc): swap line_reg<->line_bak, stay in RUN, no icache request.
  - Else -> REQ.
- Redirect:
  - Highest priority; pc <= redirect_pc_i; instr_valid_o forced 0 in that cycle.
  - A handshake in the same cycle still updates prev_pc.
  - Redirect in WAIT: drop <= 1, so the outstanding response is discarded before re-requesting.
  - Redirect in REQ: the address changes only if the request was not accepted that cycle; if accepted, go to WAIT with drop=1.
- At most one outstanding icache request.
- instr_valid_o/instr_pc_o/pc_o stable while valid & !ready.
- Backup-hit cycle takes effect next cycle; the redirect still costs one bubble.

Test Plan:
- Reset, BOOT_PC=0x100, icache returns line after 2 cycles, decode always ready -> req addr 0x100; instr_pc_o 0x100,0x104,0x108,0x10C on consecutive cycles starting at the arrival cycle; first with line_sel=cache_out, then REQ for 0x110.
- Decode stalls 3 cycles at 0x104 -> instr_pc_o held 0x104, pc_o=1 throughout; prev_pc_o=0 until accepted.
- Loop: run lines 0x100 and 0x110, redirect to 0x104 -> no icache request; swap occurs; instr_pc_o=0x104 from line_reg two cycles after redirect.
- Redirect to 0x200 while WAIT for 0x110 -> 0x110 response dropped; next request addr 0x200; no instruction from 0x110 presented.
- Redirect to 0xFFFF_FFF0 -> line fetched; after 0xFFFF_FFFC consumed, next request addr 0x0000_0000.
- rst_i asserted in WAIT with response arriving same cycle -> response ignored; next cycle all outputs reset and req addr 0x100.
